// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: Moore strobes per state, memory-state stretching
// on mem_ready with a bounded wait, and a retired-instruction counter.
module multicycle_control #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       done;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Static per-state strobes; the mem_ready-qualified ones are added on the outputs.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
         S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
            c.pc_source = 2'b01; c.done = 1'b1;
         end
         S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
         S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_ADDIWB: begin c.reg_write = 1'b1; c.done = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t             state_q, state_d;
   ctrl_t              ctrl_q;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q;
   logic               wait_last, timeout, legal_op, in_fetch, done_now;
   logic               unused_zero;

   assign unused_zero = zero;
   assign wait_last   = (wait_q == WAIT_W'(WAIT_MAX - 1));
   assign in_fetch    = (state_q == S_FETCH);

   always_comb begin
      state_d  = state_q;
      timeout  = 1'b0;
      legal_op = 1'b1;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)      state_d = S_DECODE;
            else if (wait_last) timeout = 1'b1;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      state_d = S_EXEC;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_ADDI:       state_d = S_ADDIEX;
               default: begin
                  state_d  = S_FETCH;
                  legal_op = 1'b0;
               end
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready) state_d = S_MEMWB;
            else if (wait_last) begin
               timeout = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMWR: begin
            if (mem_ready) state_d = S_FETCH;
            else if (wait_last) begin
               timeout = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC:   state_d = S_RWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Counter only survives a cycle spent stalled in a memory state; any move or abort clears it.
   always_comb begin
      wait_d = '0;
      if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
          !mem_ready && !timeout)
         wait_d = wait_q + 1'b1;
   end

   assign done_now = !rst && (ctrl_q.done || (state_q == S_MEMWR && mem_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ctrl_q    <= decode(S_FETCH);
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
         wait_q  <= wait_d;
         if (done_now) retired_q <= retired_q + 1'b1;
      end
   end

   assign PCWrite     = !rst && (ctrl_q.pc_write || (in_fetch && mem_ready));
   assign PCWriteCond = !rst && ctrl_q.pc_write_cond;
   assign IorD        = !rst && ctrl_q.iord;
   assign MemRead     = !rst && ctrl_q.mem_read;
   assign MemWrite    = !rst && ctrl_q.mem_write;
   assign IRWrite     = !rst && in_fetch && mem_ready;
   assign MemtoReg    = !rst && ctrl_q.mem_to_reg;
   assign RegDst      = !rst && ctrl_q.reg_dst;
   assign RegWrite    = !rst && ctrl_q.reg_write;
   assign ALUSrcA     = !rst && ctrl_q.alu_src_a;
   assign ALUSrcB     = rst ? 2'b00 : ctrl_q.alu_src_b;
   assign ALUOp       = rst ? 2'b00 : ctrl_q.alu_op;
   assign PCSource    = rst ? 2'b00 : ctrl_q.pc_source;
   assign state       = rst ? 4'd0 : 4'(state_q);
   assign instr_done  = done_now;
   assign illegal_op  = !rst && (state_q == S_DECODE) && !legal_op;
   assign mem_timeout = !rst && timeout;
   assign retired     = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class, waits,
// timeouts, illegal opcode and mid-wait reset against hand-written control words.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'b0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [3:0]  state;
   logic        instr_done, illegal_op, mem_timeout;
   logic [31:0] retired;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.WAIT_MAX(15), .WAIT_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired(retired)
   );

   // Word layout: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite}_{MemtoReg,RegDst,RegWrite,ALUSrcA}
   //              _{ALUSrcB}_{ALUOp}_{PCSource}_{instr_done,illegal_op,mem_timeout}
   localparam logic [18:0] C_ZERO   = 19'b000000_0000_00_00_00_000;
   localparam logic [18:0] C_FRDY   = 19'b100101_0000_01_00_00_000;
   localparam logic [18:0] C_FWAIT  = 19'b000100_0000_01_00_00_000;
   localparam logic [18:0] C_FTO    = 19'b000100_0000_01_00_00_001;
   localparam logic [18:0] C_DEC    = 19'b000000_0000_11_00_00_000;
   localparam logic [18:0] C_DECILL = 19'b000000_0000_11_00_00_010;
   localparam logic [18:0] C_MEMADR = 19'b000000_0001_10_00_00_000;
   localparam logic [18:0] C_MEMRD  = 19'b001100_0000_00_00_00_000;
   localparam logic [18:0] C_MEMWB  = 19'b000000_1010_00_00_00_100;
   localparam logic [18:0] C_WRWAIT = 19'b001010_0000_00_00_00_000;
   localparam logic [18:0] C_WRDONE = 19'b001010_0000_00_00_00_100;
   localparam logic [18:0] C_WRTO   = 19'b001010_0000_00_00_00_001;
   localparam logic [18:0] C_EXEC   = 19'b000000_0001_00_10_00_000;
   localparam logic [18:0] C_RWB    = 19'b000000_0110_00_00_00_100;
   localparam logic [18:0] C_BRANCH = 19'b010000_0001_00_01_01_100;
   localparam logic [18:0] C_JUMP   = 19'b100000_0000_00_00_10_100;
   localparam logic [18:0] C_ADDIEX = 19'b000000_0001_10_00_00_000;
   localparam logic [18:0] C_ADDIWB = 19'b000000_0010_00_00_00_100;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD = 6'b111111;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle, check the settled outputs, then advance past the next edge.
   task automatic tick(input string tag, input logic r, input logic rdy, input logic [5:0] op,
                       input logic [3:0] est, input logic [18:0] ectl, input logic [31:0] eret);
      logic [18:0] obs;
      rst = r; mem_ready = rdy; opcode = op;
      #1;
      obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             instr_done, illegal_op, mem_timeout};
      check({tag, ".state"}, 32'(state), 32'(est));
      check({tag, ".ctrl"}, 32'(obs), 32'(ectl));
      check({tag, ".retired"}, retired, eret);
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      tick("rst0", 1, 1, OP_R, 0, C_ZERO, 0);
      tick("rst1", 1, 1, OP_R, 0, C_ZERO, 0);

      tick("r.fetch", 0, 1, OP_R, 0, C_FRDY, 0);
      tick("r.dec",   0, 1, OP_R, 1, C_DEC, 0);
      tick("r.exec",  0, 1, OP_LW, 6, C_EXEC, 0);
      tick("r.rwb",   0, 1, OP_BAD, 7, C_RWB, 0);

      tick("lw.fetch", 0, 1, OP_R, 0, C_FRDY, 1);
      tick("lw.dec",   0, 1, OP_LW, 1, C_DEC, 1);
      tick("lw.adr",   0, 1, OP_LW, 2, C_MEMADR, 1);
      tick("lw.rd",    0, 1, OP_LW, 3, C_MEMRD, 1);
      tick("lw.wb",    0, 1, OP_LW, 4, C_MEMWB, 1);

      tick("sw.fetch", 0, 1, OP_SW, 0, C_FRDY, 2);
      tick("sw.dec",   0, 1, OP_SW, 1, C_DEC, 2);
      tick("sw.adr",   0, 1, OP_SW, 2, C_MEMADR, 2);
      for (int i = 0; i < 3; i++) tick("sw.wait", 0, 0, OP_SW, 5, C_WRWAIT, 2);
      tick("sw.done",  0, 1, OP_SW, 5, C_WRDONE, 2);

      tick("beq.fetch", 0, 1, OP_BEQ, 0, C_FRDY, 3);
      tick("beq.dec",   0, 1, OP_BEQ, 1, C_DEC, 3);
      tick("beq.br",    0, 1, OP_BEQ, 8, C_BRANCH, 3);

      tick("j.fetch", 0, 1, OP_J, 0, C_FRDY, 4);
      tick("j.dec",   0, 1, OP_J, 1, C_DEC, 4);
      tick("j.jump",  0, 1, OP_J, 9, C_JUMP, 4);

      tick("addi.fetch", 0, 1, OP_ADDI, 0, C_FRDY, 5);
      tick("addi.dec",   0, 1, OP_ADDI, 1, C_DEC, 5);
      tick("addi.ex",    0, 1, OP_ADDI, 10, C_ADDIEX, 5);
      tick("addi.wb",    0, 1, OP_ADDI, 11, C_ADDIWB, 5);

      tick("ill.fetch", 0, 1, OP_BAD, 0, C_FRDY, 6);
      tick("ill.dec",   0, 1, OP_BAD, 1, C_DECILL, 6);

      for (int i = 0; i < 14; i++) tick("fto.wait", 0, 0, OP_R, 0, C_FWAIT, 6);
      tick("fto.abort", 0, 0, OP_R, 0, C_FTO, 6);

      // Ready arriving on the last permitted wait cycle completes normally.
      tick("lwl.fetch", 0, 1, OP_LW, 0, C_FRDY, 6);
      tick("lwl.dec",   0, 1, OP_LW, 1, C_DEC, 6);
      tick("lwl.adr",   0, 1, OP_LW, 2, C_MEMADR, 6);
      for (int i = 0; i < 14; i++) tick("lwl.wait", 0, 0, OP_LW, 3, C_MEMRD, 6);
      tick("lwl.rd",    0, 1, OP_LW, 3, C_MEMRD, 6);
      tick("lwl.wb",    0, 1, OP_LW, 4, C_MEMWB, 6);

      tick("swto.fetch", 0, 1, OP_SW, 0, C_FRDY, 7);
      tick("swto.dec",   0, 1, OP_SW, 1, C_DEC, 7);
      tick("swto.adr",   0, 1, OP_SW, 2, C_MEMADR, 7);
      for (int i = 0; i < 14; i++) tick("swto.wait", 0, 0, OP_SW, 5, C_WRWAIT, 7);
      tick("swto.abort", 0, 0, OP_SW, 5, C_WRTO, 7);

      tick("rstw.fetch", 0, 1, OP_LW, 0, C_FRDY, 7);
      tick("rstw.dec",   0, 1, OP_LW, 1, C_DEC, 7);
      tick("rstw.adr",   0, 1, OP_LW, 2, C_MEMADR, 7);
      for (int i = 0; i < 3; i++) tick("rstw.wait", 0, 0, OP_LW, 3, C_MEMRD, 7);
      tick("rstw.rst",   1, 0, OP_LW, 0, C_ZERO, 0);
      tick("rstw.after", 0, 0, OP_LW, 0, C_FWAIT, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
